// File: rtl/i2s_tx_if.sv
// Sample-stream handshake into the I2S transmitter: one signed stereo frame per transfer.
interface i2s_tx_if #(parameter int IN_W = 17);
  logic            s_valid;
  logic            s_ready;
  logic [IN_W-1:0] s_left;
  logic [IN_W-1:0] s_right;

  modport master(output s_valid, s_left, s_right, input s_ready);
  modport slave (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/i2s_tx.sv
// Philips I2S serializer: saturating frame FIFO feeding a self-clocked BCLK/LRCLK/SDATA output.
module i2s_tx #(
  parameter int IN_W       = 17,
  parameter int OUT_W      = 16,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  i2s_tx_if.slave                       s,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int SW = $clog2(2*OUT_W);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic signed [IN_W-1:0] SMAX = IN_W'((2**(OUT_W-1)) - 1);
  localparam logic signed [IN_W-1:0] SMIN = IN_W'(-(2**(OUT_W-1)));

  typedef struct packed {
    logic [OUT_W-1:0] l;
    logic [OUT_W-1:0] r;
  } frame_t;

  function automatic logic [OUT_W-1:0] sat(input logic signed [IN_W-1:0] x);
    if (x > SMAX)      return SMAX[OUT_W-1:0];
    else if (x < SMIN) return SMIN[OUT_W-1:0];
    else               return x[OUT_W-1:0];
  endfunction

  frame_t             mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [DW-1:0]      div_cnt;
  logic [SW-1:0]      slot_cnt;
  logic [2*OUT_W-1:0] shreg;
  logic               en_q;

  logic tc, fall, slot0, full, empty, push, pop;

  always_comb begin
    tc    = (div_cnt == DW'(BCLK_DIV-1));
    fall  = en_q && tc && bclk;
    slot0 = (slot_cnt == '0);
    full  = (fifo_level == LW'(FIFO_DEPTH));
    empty = (fifo_level == '0);
    push  = s.s_valid && s.s_ready;
    pop   = fall && slot0 && !empty;
  end

  // en_q is cleared asynchronously by rst, so ready is low throughout reset
  assign s.s_ready = en_q && !full;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{l: sat(s.s_left), r: sat(s.s_right)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      div_cnt    <= '0;
      slot_cnt   <= '0;
      bclk       <= 1'b0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      underrun   <= 1'b0;
      shreg      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (!en) begin
      en_q       <= 1'b0;
      div_cnt    <= '0;
      slot_cnt   <= '0;
      bclk       <= 1'b0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      underrun   <= 1'b0;
      shreg      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      en_q     <= 1'b1;
      underrun <= 1'b0;
      // counting starts the edge after en is first seen, so the first fall lands 2*BCLK_DIV later
      if (en_q) begin
        div_cnt <= tc ? '0 : div_cnt + 1'b1;
        if (tc) bclk <= ~bclk;
        if (fall) begin
          slot_cnt <= (slot_cnt == SW'(2*OUT_W-1)) ? '0 : slot_cnt + 1'b1;
          lrclk    <= (slot_cnt >= SW'(OUT_W));
          // MSB out every slot; at slot 0 that is the previous right LSB, giving the one-slot delay
          sdata    <= shreg[2*OUT_W-1];
          if (slot0) begin
            shreg    <= empty ? '0 : mem[rd_ptr];
            underrun <= empty;
          end else begin
            shreg <= shreg << 1;
          end
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end
endmodule
